// File: rtl/dr32e_pkg.sv
// Shared types and constants for the dr32e fetch path.
package dr32e_pkg;

    // One buffered memory response word together with its bus-error flag.
    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } fetch_entry_t;

    // Low two bits of a halfword that mark the start of a 32-bit instruction.
    localparam logic [1:0] INSTR_32B = 2'b11;

endpackage

// File: rtl/dr32e_fetch_fifo.sv
// Instruction fetch buffer: stores word-aligned memory responses in a small
// circular buffer and hands out one re-aligned instruction (16- or 32-bit)
// per handshake, tracking the PC of the instruction at the head.
module dr32e_fetch_fifo
    import dr32e_pkg::*;
#(
    parameter int unsigned DEPTH    = 3,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic [31:0] clear_addr_i,
    input  logic        in_valid_i,
    input  logic [31:0] in_rdata_i,
    input  logic        in_err_i,
    output logic        in_ready_o,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_rdata_o,
    output logic [31:0] out_addr_o,
    output logic        out_is_comp_o,
    output logic        out_err_o,
    output logic        out_err_plus2_o,
    output logic        busy_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH + 1);

    fetch_entry_t   entry_reg [DEPTH];
    logic [PW-1:0]  rd_ptr_reg;
    logic [PW-1:0]  wr_ptr_reg;
    logic [LW-1:0]  level_reg;
    logic [31:0]    addr_reg;

    fetch_entry_t   entry0;
    fetch_entry_t   entry1;
    logic [PW-1:0]  rd_ptr_next;
    logic           offset;
    logic           level_ge1;
    logic           level_ge2;
    logic [15:0]    hw0;
    logic           comp;
    logic           push;
    logic           pop_fire;
    logic           pop_word;
    logic           err_first;
    logic           err_second;

    // Pointers wrap modulo DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Head decode: pick the current halfword, classify it and build the aligned instruction.
    always_comb begin
        rd_ptr_next = ptr_inc(rd_ptr_reg);
        entry0      = entry_reg[rd_ptr_reg];
        entry1      = entry_reg[rd_ptr_next];
        offset      = addr_reg[1];
        level_ge1   = (level_reg != '0);
        level_ge2   = (level_reg >= LW'(2));
        hw0         = offset ? entry0.rdata[31:16] : entry0.rdata[15:0];
        comp        = (hw0[1:0] != INSTR_32B);

        // An unaligned 32-bit instruction needs the next word unless the first already faulted.
        out_valid_o = level_ge1 && (comp || !offset || level_ge2 || entry0.err);

        if (comp) begin
            out_rdata_o = {16'h0, hw0};
        end else if (offset) begin
            out_rdata_o = {entry1.rdata[15:0], entry0.rdata[31:16]};
        end else begin
            out_rdata_o = entry0.rdata;
        end

        err_first       = level_ge1 && entry0.err;
        err_second      = level_ge2 && !comp && offset && entry1.err;
        out_err_o       = err_first || err_second;
        out_err_plus2_o = out_err_o && !err_first;
        out_is_comp_o   = comp;
        out_addr_o      = addr_reg;

        in_ready_o      = (level_reg < LW'(DEPTH));
        busy_o          = level_ge1;

        push            = in_valid_i && in_ready_o;
        pop_fire        = out_valid_o && out_ready_i;
        // A word retires unless we only consumed its lower compressed halfword.
        pop_word        = pop_fire && (!comp || offset);
    end

    // Pointer, level and PC bookkeeping; flush/retarget takes priority over traffic.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            level_reg  <= '0;
            addr_reg   <= RESET_PC;
        end else if (clear_i) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            level_reg  <= '0;
            addr_reg   <= {clear_addr_i[31:1], 1'b0};
        end else begin
            if (push) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (pop_word) begin
                rd_ptr_reg <= rd_ptr_next;
            end
            case ({push, pop_word})
                2'b10:   level_reg <= level_reg + LW'(1);
                2'b01:   level_reg <= level_reg - LW'(1);
                default: level_reg <= level_reg;
            endcase
            if (pop_fire) begin
                addr_reg <= addr_reg + (comp ? 32'd2 : 32'd4);
            end
        end
    end

    // Storage: write the accepted response word at the tail slot; entries never shift.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                entry_reg[i] <= '0;
            end
        end else if (push && !clear_i) begin
            entry_reg[wr_ptr_reg] <= '{rdata: in_rdata_i, err: in_err_i};
        end
    end

    // Upstream must hold its response while the buffer is full.
    always_ff @(posedge clk_i) begin
        if (!rst_i && !clear_i) begin
            assert (!(in_valid_i && !in_ready_o));
        end
    end

endmodule

// File: tb/tb_dr32e_fetch_fifo.sv
// Bench for dr32e_fetch_fifo: directed scenarios followed by random traffic,
// every cycle compared against a halfword-stream reference model.
module tb_dr32e_fetch_fifo;

    localparam int unsigned DEPTH    = 3;
    localparam logic [31:0] RESET_PC = 32'h0000_0080;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        clear_i;
    logic [31:0] clear_addr_i;
    logic        in_valid_i;
    logic [31:0] in_rdata_i;
    logic        in_err_i;
    logic        in_ready_o;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_rdata_o;
    logic [31:0] out_addr_o;
    logic        out_is_comp_o;
    logic        out_err_o;
    logic        out_err_plus2_o;
    logic        busy_o;

    dr32e_fetch_fifo #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .clear_i        (clear_i),
        .clear_addr_i   (clear_addr_i),
        .in_valid_i     (in_valid_i),
        .in_rdata_i     (in_rdata_i),
        .in_err_i       (in_err_i),
        .in_ready_o     (in_ready_o),
        .out_valid_o    (out_valid_o),
        .out_ready_i    (out_ready_i),
        .out_rdata_o    (out_rdata_o),
        .out_addr_o     (out_addr_o),
        .out_is_comp_o  (out_is_comp_o),
        .out_err_o      (out_err_o),
        .out_err_plus2_o(out_err_plus2_o),
        .busy_o         (busy_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: the program is a stream of halfwords, each tagged with the
    // error flag of the word it came from; skip drops the lower halfword of the
    // next arriving word when the fetch PC points at an upper halfword.
    logic [15:0] hq[$];
    bit          he[$];
    logic [31:0] m_pc;
    bit          skip;

    bit          e_valid, e_comp, e_err, e_plus2, e_complete;
    logic [31:0] e_rdata;

    function automatic int m_words();
        if (hq.size() == 0) return 0;
        return (int'(m_pc[1]) + hq.size() + 1) / 2;
    endfunction

    task automatic calc();
        logic [15:0] h0;
        e_valid = 0; e_comp = 0; e_err = 0; e_plus2 = 0; e_complete = 1; e_rdata = '0;
        if (hq.size() >= 1) begin
            h0     = hq[0];
            e_comp = (h0[1:0] != 2'b11);
            if (e_comp) begin
                e_valid = 1; e_rdata = {16'h0, h0}; e_err = he[0];
            end else if (hq.size() >= 2) begin
                e_valid = 1; e_rdata = {hq[1], hq[0]};
                e_err   = he[0] | he[1];
                e_plus2 = !he[0] && he[1];
            end else if (he[0]) begin
                e_valid = 1; e_err = 1; e_complete = 0;
            end
        end
    endtask

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check();
        cmp("valid",    32'(out_valid_o), 32'(e_valid));
        cmp("in_ready", 32'(in_ready_o),  32'(m_words() < int'(DEPTH)));
        cmp("busy",     32'(busy_o),      32'(m_words() != 0));
        cmp("addr",     out_addr_o,       m_pc);
        if (e_valid) begin
            cmp("is_comp", 32'(out_is_comp_o),   32'(e_comp));
            cmp("err",     32'(out_err_o),       32'(e_err));
            cmp("plus2",   32'(out_err_plus2_o), 32'(e_plus2));
            if (!(e_err && !e_complete)) cmp("rdata", out_rdata_o, e_rdata);
        end
    endtask

    task automatic model_reset(input logic [31:0] pc);
        hq.delete(); he.delete();
        m_pc = pc;
        skip = pc[1];
    endtask

    // One clock: check current outputs, apply inputs, advance DUT and model together.
    task automatic cycle(input bit v, input logic [31:0] d, input bit e, input bit rdy,
                         input bit clr, input logic [31:0] ca, input bit r);
        bit do_push, do_pop;
        calc();
        check();
        rst_i = r; clear_i = clr; clear_addr_i = ca;
        in_valid_i = v; in_rdata_i = d; in_err_i = e; out_ready_i = rdy;
        do_push = v && (m_words() < int'(DEPTH));
        do_pop  = e_valid && rdy;
        @(posedge clk);
        if (r) begin
            model_reset(RESET_PC);
        end else if (clr) begin
            model_reset({ca[31:1], 1'b0});
        end else begin
            if (do_pop) begin
                if (e_comp) begin
                    void'(hq.pop_front()); void'(he.pop_front());
                    m_pc = m_pc + 32'd2;
                end else begin
                    void'(hq.pop_front()); void'(he.pop_front());
                    if (hq.size() > 0) begin
                        void'(hq.pop_front()); void'(he.pop_front());
                    end else begin
                        skip = 1;
                    end
                    m_pc = m_pc + 32'd4;
                end
            end
            if (do_push) begin
                if (!skip) begin
                    hq.push_back(d[15:0]); he.push_back(e);
                end
                skip = 0;
                hq.push_back(d[31:16]); he.push_back(e);
            end
        end
        #1;
        $display("cyc v=%0b d=%h e=%0b rdy=%0b clr=%0b rst=%0b -> ov=%0b od=%h oa=%h lvl=%0d",
                 v, d, e, rdy, clr, r, out_valid_o, out_rdata_o, out_addr_o, m_words());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 32'h0, 0, 0, 0, 32'h0, 0);
    endtask

    initial begin
        rst_i = 1; clear_i = 0; clear_addr_i = '0;
        in_valid_i = 0; in_rdata_i = '0; in_err_i = 0; out_ready_i = 0;
        repeat (2) @(posedge clk);
        #1;
        model_reset(RESET_PC);
        rst_i = 0;

        // Reset state
        cmp("rst_rdata", out_rdata_o, 32'h0);
        cmp("rst_err",   32'(out_err_o), 32'h0);
        cmp("rst_plus2", 32'(out_err_plus2_o), 32'h0);
        idle(1);

        // Single aligned 32-bit instruction, one-cycle latency, then pop
        cycle(1, 32'h0000_0013, 0, 0, 0, 32'h0, 0);
        cycle(0, 32'h0, 0, 1, 0, 32'h0, 0);
        idle(1);

        // Two compressed instructions in one word
        cycle(1, 32'h4505_4501, 0, 0, 0, 32'h0, 0);
        cycle(0, 32'h0, 0, 1, 0, 32'h0, 0);
        cycle(0, 32'h0, 0, 0, 0, 32'h0, 0);
        cycle(0, 32'h0, 0, 1, 0, 32'h0, 0);
        idle(1);

        // Unaligned 32-bit instruction spanning two words
        cycle(0, 32'h0, 0, 0, 1, 32'h0000_0102, 0);
        cycle(1, 32'h0093_abcd, 0, 0, 0, 32'h0, 0);
        idle(1);
        cycle(1, 32'hbeef_0010, 0, 0, 0, 32'h0, 0);
        cycle(0, 32'h0, 0, 1, 0, 32'h0, 0);
        idle(1);

        // Fill to DEPTH, then drain by popping alone
        cycle(0, 32'h0, 0, 0, 1, 32'h0000_0200, 0);
        for (int i = 0; i < int'(DEPTH); i++) cycle(1, 32'h0000_0013 + 32'(i << 7), 0, 0, 0, 32'h0, 0);
        idle(1);
        for (int i = 0; i < int'(DEPTH); i++) cycle(0, 32'h0, 0, 1, 0, 32'h0, 0);
        idle(1);

        // Error on the second word of an unaligned 32-bit instruction
        cycle(0, 32'h0, 0, 0, 1, 32'h0000_0302, 0);
        cycle(1, 32'h0093_0000, 0, 0, 0, 32'h0, 0);
        cycle(1, 32'h0000_0010, 1, 0, 0, 32'h0, 0);
        idle(1);
        cycle(0, 32'h0, 0, 1, 0, 32'h0, 0);

        // Error on the first word: valid before the second word arrives
        cycle(0, 32'h0, 0, 0, 1, 32'h0000_0402, 0);
        cycle(1, 32'h0093_0000, 1, 0, 0, 32'h0, 0);
        idle(1);
        cycle(0, 32'h0, 0, 1, 0, 32'h0, 0);
        cycle(1, 32'h1111_0001, 0, 0, 0, 32'h0, 0);
        idle(1);

        // Clear in the same cycle as push and pop
        cycle(1, 32'h0000_0013, 0, 0, 0, 32'h0, 0);
        cycle(1, 32'h4505_4501, 0, 1, 1, 32'h0000_0500, 0);
        idle(1);

        // Reset in the middle of traffic, overriding a clear
        cycle(1, 32'h0000_0013, 0, 0, 0, 32'h0, 0);
        cycle(1, 32'h0000_0013, 0, 1, 1, 32'h0000_0600, 1);
        idle(1);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            logic [31:0] d;
            bit v, e, rdy, clr;
            d = $urandom();
            if ($urandom_range(1, 0) == 1) d[1:0] = 2'b11;
            if ($urandom_range(1, 0) == 1) d[17:16] = 2'b11;
            v   = ($urandom_range(2, 0) != 0) && (m_words() < int'(DEPTH));
            e   = ($urandom_range(15, 0) == 0);
            rdy = ($urandom_range(3, 0) != 0);
            clr = ($urandom_range(39, 0) == 0);
            cycle(v, d, e, rdy, clr, $urandom(), 0);
        end
        idle(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
